sd_seq_monitor: RTL and testbench
=================================

SD_SEQ_MONITOR -- requirements
Module: sd_seq_monitor

Interface
REQ-001 Parameter: width, 8, data word width in bits.
REQ-002 Parameter: cnt_width, 16, width of the ok and error counters.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: c_srdy  input  1  upstream has valid data.
REQ-006 Port: c_drdy  output  1  monitor accepts data this cycle.
REQ-007 Port: c_data  input  width  upstream data word.
REQ-008 Port: enable  input  1  1 = run; 0 = return to IDLE at the next edge.
REQ-009 Port: load_pat  input  1  one-cycle pulse; loads pat_in into the pattern register.
REQ-010 Port: pat_in  input  8  new drdy pattern.
REQ-011 Port: ok_cnt  output  cnt_width  count of in-sequence words.
REQ-012 Port: err_cnt  output  cnt_width  count of out-of-sequence words.
REQ-013 Port: err_flag  output  1  sticky flag, set on the first mismatch.
REQ-014 Port: bad_data  output  width  c_data value of the most recent mismatch.
REQ-015 Port: synced  output  1  high in CHECK and ERR states.

Function
REQ-016 A transfer occurs when c_srdy=1 and c_drdy=1 in the same cycle; no other cycle consumes data.
REQ-017 c_drdy SHALL be the combinational AND of pat_q[0] and (state != IDLE); it SHALL NOT depend on c_srdy.
REQ-018 pat_q is an 8-bit register that rotates right by one bit every cycle; the outgoing pat_q[0] wraps into bit 7.
REQ-019 When load_pat=1, pat_q SHALL load pat_in in place of rotating; a pat_in value of 8'h00 SHALL load 8'h01 so the block cannot deadlock.
REQ-020 States: IDLE, SYNC, CHECK, ERR.
REQ-021 IDLE->SYNC when enable=1. Any state->IDLE when enable=0, including a cycle with a transfer in flight; that word is still counted.
REQ-022 SYNC: the first transfer sets exp = c_data+1 (mod 2^width), moves to CHECK, and counts nothing.
REQ-023 CHECK, transfer, c_data==exp: ok_cnt+1, exp = exp+1 (mod 2^width), stay in CHECK.
REQ-024 CHECK, transfer, c_data!=exp: err_cnt+1, err_flag=1, bad_data=c_data, exp = c_data+1 (resync), go to ERR.
REQ-025 ERR lasts exactly one cycle, then goes to CHECK; a transfer in ERR is checked exactly as in CHECK, and a mismatch there keeps the state in ERR.
REQ-026 exp wraps from all-ones to zero; data 8'hFF followed by 8'h00 is in sequence.
REQ-027 ok_cnt and err_cnt SHALL saturate at all-ones and never wrap.
REQ-028 Counters, err_flag and bad_data hold their values through IDLE; only reset clears them.
REQ-029 Latency: counters, err_flag and bad_data update at the clock edge that ends the transfer cycle.

Reset
REQ-030 Reset values: state=IDLE, pat_q=8'hFF, exp=0, ok_cnt=0, err_cnt=0, err_flag=0, bad_data=0; so c_drdy=0 and synced=0.
REQ-031 Reset has priority over enable and load_pat. Reset in mid-stream discards exp, and the next run re-enters through SYNC.

Structure
REQ-032 The state encodings (2-bit) and the pattern reset value SHALL be localparams in the shared sd header include, so the bench can decode state.
REQ-033 The block SHALL instantiate sd_sat_counter (params: width; ports: clk, reset, inc, count) twice, once for ok_cnt and once for err_cnt.

Verification
REQ-034 enable=1; source sends 0,1,2,...,99 with c_srdy held high; pat_q=8'hFF -> ok_cnt=99, err_cnt=0, the 100 transfers take 100 cycles, synced=1.
REQ-035 Load pat_in=8'h5A; stream 200 words -> c_drdy follows the 8-cycle pattern 0,1,0,1,1,0,1,0; ok_cnt=199; every word is accepted exactly once.
REQ-036 Stream 10,11,13,14 -> err_cnt=1, bad_data=13, err_flag=1; 14 counts as ok through the ERR state; ok_cnt=2.
REQ-037 Stream 8'hFE,8'hFF,8'h00,8'h01 -> ok_cnt=3, err_cnt=0.
REQ-038 Load pat_in=8'h00 -> pat_q=8'h01, and c_drdy pulses once every 8 cycles.
REQ-039 Force counters to saturation (cnt_width=4, 20 ok words) -> ok_cnt=4'hF. Then assert reset mid-stream -> all outputs return to reset values, and the first word after re-enable is consumed in SYNC.

Source files
------------

// File: rtl/sd_seq_monitor_pkg.sv
// Shared definitions for the sequence monitor: state encodings, pattern reset
// value and the pattern-load sanitiser.
package sd_seq_monitor_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SYNC_ENC  = 2'd1;
  localparam logic [1:0] ST_CHECK_ENC = 2'd2;
  localparam logic [1:0] ST_ERR_ENC   = 2'd3;

  localparam logic [7:0] PAT_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SYNC  = ST_SYNC_ENC,
    ST_CHECK = ST_CHECK_ENC,
    ST_ERR   = ST_ERR_ENC
  } state_t;

  // An all-zero pattern would never assert drdy, so it is replaced by 8'h01.
  function automatic logic [7:0] pat_sanitize(input logic [7:0] p);
    return (p == 8'h00) ? 8'h01 : p;
  endfunction

endpackage

// File: rtl/sd_seq_monitor_if.sv
// srdy/drdy handshake bus between a data source and the sequence monitor.
interface sd_seq_monitor_if #(
  parameter int width = 8
);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;

  modport master (output c_srdy, output c_data, input c_drdy);
  modport slave  (input c_srdy, input c_data, output c_drdy);
endinterface

// File: rtl/sd_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sd_sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + width'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/sd_seq_monitor.sv
// Checks that accepted words form an incrementing sequence, throttling
// acceptance with a rotating drdy pattern and counting good/bad words.
module sd_seq_monitor
  import sd_seq_monitor_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_seq_monitor_if.slave      c,
  input  logic                 enable,
  input  logic                 load_pat,
  input  logic [7:0]           pat_in,
  output logic [cnt_width-1:0] ok_cnt,
  output logic [cnt_width-1:0] err_cnt,
  output logic                 err_flag,
  output logic [width-1:0]     bad_data,
  output logic                 synced
);

  state_t           state_reg, state_next;
  logic [7:0]       pat_reg;
  logic [width-1:0] exp_reg, exp_next;
  logic             err_flag_reg;
  logic [width-1:0] bad_data_reg;
  logic             xfer;
  logic             ok_inc, err_inc, mismatch;
  logic [1:0]       inc_vec;
  logic [cnt_width-1:0] cnt_vec [2];

  assign c.c_drdy = pat_reg[0] && (state_reg != ST_IDLE);
  assign xfer     = c.c_srdy && c.c_drdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_reg      <= PAT_RESET;
      state_reg    <= ST_IDLE;
      exp_reg      <= '0;
      err_flag_reg <= 1'b0;
      bad_data_reg <= '0;
    end else begin
      pat_reg   <= load_pat ? pat_sanitize(pat_in) : {pat_reg[0], pat_reg[7:1]};
      state_reg <= state_next;
      exp_reg   <= exp_next;
      if (mismatch) begin
        err_flag_reg <= 1'b1;
        bad_data_reg <= c.c_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    exp_next   = exp_reg;
    ok_inc     = 1'b0;
    err_inc    = 1'b0;
    mismatch   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (xfer) begin
          exp_next   = c.c_data + width'(1);
          state_next = ST_CHECK;
        end
      end
      ST_CHECK, ST_ERR: begin
        state_next = ST_CHECK;
        if (xfer) begin
          if (c.c_data == exp_reg) begin
            ok_inc   = 1'b1;
            exp_next = exp_reg + width'(1);
          end else begin
            err_inc    = 1'b1;
            mismatch   = 1'b1;
            exp_next   = c.c_data + width'(1);
            state_next = ST_ERR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Dropping enable wins over any transition, but the word above still counts.
    if (!enable) state_next = ST_IDLE;
  end

  assign inc_vec = {err_inc, ok_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sd_sat_counter #(.width(cnt_width)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[gi]),
        .count (cnt_vec[gi])
      );
    end
  endgenerate

  assign ok_cnt   = cnt_vec[0];
  assign err_cnt  = cnt_vec[1];
  assign err_flag = err_flag_reg;
  assign bad_data = bad_data_reg;
  assign synced   = (state_reg == ST_CHECK) || (state_reg == ST_ERR);

endmodule

// File: tb/tb_sd_seq_monitor.sv
// Directed bench for sd_seq_monitor: a 16-bit-counter instance for function
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_sd_seq_monitor;

  logic        clk = 1'b0;
  logic        reset, enable, load_pat;
  logic [7:0]  pat_in;
  logic [15:0] ok_cnt, err_cnt;
  logic        err_flag, synced;
  logic [7:0]  bad_data;
  logic [3:0]  ok_cnt4, err_cnt4;
  logic        err_flag4, synced4;
  logic [7:0]  bad_data4;

  int errors = 0;
  int checks = 0;
  logic [7:0] words [$];
  int pat_errs;

  sd_seq_monitor_if #(.width(8)) bus ();
  sd_seq_monitor_if #(.width(8)) bus4 ();
  assign bus4.c_srdy = bus.c_srdy;
  assign bus4.c_data = bus.c_data;

  always #5 clk = ~clk;

  sd_seq_monitor #(.width(8), .cnt_width(16)) dut (
    .clk(clk), .reset(reset), .c(bus.slave), .enable(enable), .load_pat(load_pat),
    .pat_in(pat_in), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
    .bad_data(bad_data), .synced(synced)
  );

  sd_seq_monitor #(.width(8), .cnt_width(4)) dut4 (
    .clk(clk), .reset(reset), .c(bus4.slave), .enable(enable), .load_pat(load_pat),
    .pat_in(pat_in), .ok_cnt(ok_cnt4), .err_cnt(err_cnt4), .err_flag(err_flag4),
    .bad_data(bad_data4), .synced(synced4)
  );

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load_pat = 1'b0; bus.c_srdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present words[] with srdy held high; optionally check drdy against a pattern.
  task automatic stream(output int cycles, input bit check_pat, input logic [7:0] pat);
    int i = 0;
    logic d;
    logic exp_d;
    logic [7:0] p;
    p = pat;
    cycles = 0;
    pat_errs = 0;
    bus.c_srdy = 1'b1;
    bus.c_data = words[0];
    while (i < words.size() && cycles < 3000) begin
      @(negedge clk);
      d = bus.c_drdy;
      exp_d = p[cycles % 8];
      if (check_pat && (d !== exp_d)) pat_errs++;
      @(posedge clk); #1;
      cycles++;
      if (d) begin
        i++;
        if (i < words.size()) bus.c_data = words[i];
      end
    end
    bus.c_srdy = 1'b0;
    checks++;
    if (i != words.size()) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d words, required %0d", i, words.size());
    end
    $display("stream: %0d words in %0d cycles, ok=%0d err=%0d", i, cycles, ok_cnt, err_cnt);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.c_drdy !== 1'b0) begin errors++; $display("FAIL reset_drdy: got %b want 0", bus.c_drdy); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced: got %b want 0", synced); end
    checks++; if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got ok=%0h err=%0h want 0,0", ok_cnt, err_cnt); end
    checks++; if (err_flag !== 1'b0 || bad_data !== 8'h00) begin errors++; $display("FAIL reset_err: got flag=%b bad=%0h want 0,0", err_flag, bad_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_rate();
    int cyc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    words.delete();
    for (int k = 0; k < 100; k++) words.push_back(8'(k));
    stream(cyc, 1'b0, 8'hFF);
    checks++; if (cyc != 100) begin errors++; $display("FAIL full_rate_cycles: got %0d want 100", cyc); end
    @(negedge clk);
    checks++; if (ok_cnt !== 16'd99) begin errors++; $display("FAIL full_rate_ok: got %0d want 99", ok_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL full_rate_err: got %0d want 0", err_cnt); end
    checks++; if (synced !== 1'b1) begin errors++; $display("FAIL full_rate_synced: got %b want 1", synced); end
    @(posedge clk); #1;
  endtask

  task automatic test_pattern();
    int cyc;
    do_reset();
    enable = 1'b1; load_pat = 1'b1; pat_in = 8'h5A;
    @(posedge clk); #1;
    load_pat = 1'b0;
    words.delete();
    for (int k = 0; k < 200; k++) words.push_back(8'(k));
    // Cycle k after the load sees drdy = bit k of 8'b0101_1010 (LSB first).
    stream(cyc, 1'b1, 8'b0101_1010);
    checks++; if (pat_errs != 0) begin errors++; $display("FAIL pattern_drdy: got %0d wrong cycles want 0", pat_errs); end
    @(negedge clk);
    checks++; if (ok_cnt !== 16'd199) begin errors++; $display("FAIL pattern_ok: got %0d want 199", ok_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL pattern_err: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_mismatch();
    int cyc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    words = '{8'd10, 8'd11, 8'd13, 8'd14};
    stream(cyc, 1'b0, 8'hFF);
    @(negedge clk);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_err: got %0d want 1", err_cnt); end
    checks++; if (ok_cnt !== 16'd2) begin errors++; $display("FAIL mismatch_ok: got %0d want 2", ok_cnt); end
    checks++; if (bad_data !== 8'd13) begin errors++; $display("FAIL mismatch_bad: got %0d want 13", bad_data); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL mismatch_flag: got %b want 1", err_flag); end
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL idle_synced: got %b want 0", synced); end
    checks++; if (bad_data !== 8'd13 || err_flag !== 1'b1 || err_cnt !== 16'd1) begin
      errors++; $display("FAIL idle_hold: got bad=%0d flag=%b err=%0d want 13,1,1", bad_data, err_flag, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    words = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    stream(cyc, 1'b0, 8'hFF);
    @(negedge clk);
    checks++; if (ok_cnt !== 16'd3 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL wrap: got ok=%0d err=%0d want 3,0", ok_cnt, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_pat();
    int wrong = 0;
    int hits = 0;
    do_reset();
    enable = 1'b1; load_pat = 1'b1; pat_in = 8'h00;
    @(posedge clk); #1;
    load_pat = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.c_drdy === 1'b1) hits++;
      if (bus.c_drdy !== ((k % 8) == 0)) wrong++;
      @(posedge clk); #1;
    end
    checks++; if (wrong != 0) begin errors++; $display("FAIL zero_pat_phase: got %0d wrong cycles want 0", wrong); end
    checks++; if (hits != 3) begin errors++; $display("FAIL zero_pat_pulses: got %0d want 3", hits); end
  endtask

  task automatic test_enable_drop();
    int cyc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    words = '{8'd0, 8'd1, 8'd2};
    stream(cyc, 1'b0, 8'hFF);
    bus.c_srdy = 1'b1; bus.c_data = 8'd3; enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.c_drdy !== 1'b1) begin errors++; $display("FAIL drop_drdy: got %b want 1", bus.c_drdy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ok_cnt !== 16'd3) begin errors++; $display("FAIL drop_counted: got %0d want 3", ok_cnt); end
    checks++; if (synced !== 1'b0 || bus.c_drdy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got synced=%b drdy=%b want 0,0", synced, bus.c_drdy);
    end
    @(posedge clk); #1;
    bus.c_srdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    words.delete();
    for (int k = 0; k < 21; k++) words.push_back(8'(k));
    stream(cyc, 1'b0, 8'hFF);
    @(negedge clk);
    checks++; if (ok_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_ok4: got %0h want f", ok_cnt4); end
    checks++; if (ok_cnt !== 16'd20) begin errors++; $display("FAIL sat_ok16: got %0d want 20", ok_cnt); end
    @(posedge clk); #1;
    // Reset mid-stream while enable and load_pat are also asserted.
    bus.c_srdy = 1'b1; bus.c_data = 8'd99; load_pat = 1'b1; pat_in = 8'h00; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; load_pat = 1'b0;
    @(negedge clk);
    checks++; if (bus.c_drdy !== 1'b0 || synced !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got drdy=%b synced=%b want 0,0", bus.c_drdy, synced);
    end
    checks++; if (ok_cnt !== 16'd0 || ok_cnt4 !== 4'h0 || err_cnt !== 16'd0 || err_flag !== 1'b0 || bad_data !== 8'h00) begin
      errors++; $display("FAIL midreset_outputs: got ok=%0d ok4=%0d err=%0d flag=%b bad=%0h want 0,0,0,0,0",
                         ok_cnt, ok_cnt4, err_cnt, err_flag, bad_data);
    end
    @(posedge clk); #1;
    words = '{8'd50, 8'd51, 8'd52};
    stream(cyc, 1'b0, 8'hFF);
    checks++; if (cyc != 3) begin errors++; $display("FAIL midreset_pat: got %0d cycles want 3", cyc); end
    @(negedge clk);
    checks++; if (ok_cnt !== 16'd2 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_resync: got ok=%0d err=%0d want 2,0", ok_cnt, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load_pat = 1'b0; pat_in = 8'h00;
    bus.c_srdy = 1'b0; bus.c_data = 8'h00;
    test_reset();
    test_full_rate();
    test_pattern();
    test_mismatch();
    test_wrap();
    test_zero_pat();
    test_enable_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
